// File: rtl/fifo_pkg.sv
// Shared FIFO constants and Gray-code helpers for the write/read pointer controllers.
// Helpers work on any pointer width up to PTR_MAX_W; callers zero-extend and keep the low bits.
package fifo_pkg;

  localparam int PTR_MAX_W      = 32;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int MEM_DEPTH_DEF  = 16;
  localparam int SYNC_STAGES    = 2;

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Zero-extended Gray input decodes correctly in the low bits: upper prefix XOR stays 0.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
    logic [PTR_MAX_W-1:0] bin;
    bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Two-flop synchronizer for a Gray-coded FIFO pointer crossing into the local clock domain.
// Width and reset value are parameters so the read-side controller can reuse it.
module fifo_ptr_sync #(
  parameter int               WIDTH   = 5,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q1 <= RST_VAL;
      q  <= RST_VAL;
    end else begin
      q1 <= d;
      q  <= q1;
    end
  end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-domain controller of the async FIFO: write pointer, address, registered full, level.
// Optional sticky overflow flag is built only when WR_OVERFLOW_EN is defined.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int MEM_DEPTH    = MEM_DEPTH_DEF,
  parameter int ADD_WIDTH    = $clog2(MEM_DEPTH),
  parameter int AFULL_THRESH = MEM_DEPTH - 2
) (
  input  logic               wr_clk,
  input  logic               wr_rst,
  input  logic               wr_inc,
  input  logic [ADD_WIDTH:0] rd_ptr_gray,
  output logic [ADD_WIDTH-1:0] wr_addr,
  output logic               wr_full,
  output logic [ADD_WIDTH:0] wr_ptr_gray,
  output logic [ADD_WIDTH:0] wr_level,
  output logic               wr_afull,
  output logic               wr_overflow
);

  localparam int PW = ADD_WIDTH + 1;
  localparam int unused_data_width = DATA_WIDTH;

  if (MEM_DEPTH < 4 || (MEM_DEPTH & (MEM_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_wr_ctrl: MEM_DEPTH must be a power of 2 and >= 4");
  end

  logic [ADD_WIDTH:0] wr_ptr_bin;
  logic [ADD_WIDTH:0] bin_next;
  logic [ADD_WIDTH:0] gray_next;
  logic [ADD_WIDTH:0] rq2;
  logic [ADD_WIDTH:0] rq2_bin;
  logic [ADD_WIDTH:0] full_pattern;
  logic               wr_en;
  logic               full_next;
  logic [PTR_MAX_W-PW-1:0] unused_gray_hi;
  logic [PTR_MAX_W-PW-1:0] unused_bin_hi;

  fifo_ptr_sync #(
    .WIDTH   (PW),
    .RST_VAL ('0)
  ) u_rd_sync (
    .clk (wr_clk),
    .rst (wr_rst),
    .d   (rd_ptr_gray),
    .q   (rq2)
  );

  assign wr_en    = wr_inc & ~wr_full;
  assign bin_next = wr_ptr_bin + PW'(wr_en);

  assign {unused_gray_hi, gray_next} = bin2gray(PTR_MAX_W'(bin_next));
  assign {unused_bin_hi, rq2_bin}    = gray2bin(PTR_MAX_W'(rq2));

  // Full when the next write pointer is one lap ahead of the synchronized read pointer.
  assign full_pattern = {~rq2[ADD_WIDTH:ADD_WIDTH-1], rq2[ADD_WIDTH-2:0]};
  assign full_next    = (gray_next == full_pattern);

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      wr_ptr_bin  <= '0;
      wr_ptr_gray <= '0;
      wr_full     <= 1'b0;
    end else begin
      wr_ptr_bin  <= bin_next;
      wr_ptr_gray <= gray_next;
      wr_full     <= full_next;
    end
  end

  assign wr_addr  = wr_ptr_bin[ADD_WIDTH-1:0];
  // Synchronized read pointer lags, so the level can only over-report.
  assign wr_level = wr_ptr_bin - rq2_bin;
  assign wr_afull = (wr_level >= PW'(AFULL_THRESH));

`ifdef WR_OVERFLOW_EN
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      wr_overflow <= 1'b0;
    end else if (wr_inc & wr_full) begin
      wr_overflow <= 1'b1;
    end
  end
`else
  assign wr_overflow = 1'b0;
`endif

endmodule
